sseg_scan_controller: RTL and testbench
=======================================

SSEG_SCAN_CONTROLLER -- requirements
Module: sseg_scan_controller

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles per digit slot; SHALL be >= 4.
REQ-002 Parameter DEAD_CYCLES, default 4: blanked cycles at the start of each slot (anti-ghosting); SHALL satisfy 1 <= DEAD_CYCLES < REFRESH_DIV.
REQ-003 One clock; reset is asynchronous and active-low. Ports: clk_i and rst_ni.
REQ-004 clk_i  input  1  system clock; all state on rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 enable_i  input  1  scanning enabled.
REQ-007 valid_i  input  1  new frame offered.
REQ-008 value_i  input  16  four BCD digits; [3:0] is digit 0 (rightmost).
REQ-009 dp_i  input  4  decimal-point request per digit, active-high.
REQ-010 lzb_i  input  1  leading-zero blanking for the offered frame.
REQ-011 ready_o  output  1  frame can be accepted.
REQ-012 digit_o  output  4  code for the selected digit, feeding the external 7-segment decoder.
REQ-013 an_o  output  4  digit anodes, active-low, at most one bit low.
REQ-014 dp_o  output  1  decimal point, active-low.
REQ-015 frame_o  output  1  one-cycle pulse at each digit-3-to-digit-0 wrap.

Function
REQ-016 Handshake: a frame SHALL be captured into a shadow register when valid_i && ready_o; pending is then set and ready_o = !pending.
REQ-017 Shadow-to-active transfer SHALL occur only on the cycle that idx wraps 3->0, or on any cycle while in state OFF; pending clears on that cycle.
REQ-018 Acceptance and a wrap in the same cycle: the new frame goes to the shadow and is applied at the next wrap, not the current one.
REQ-019 States: OFF, GAP, ON. OFF -> GAP when enable_i = 1. GAP -> ON when cnt reaches DEAD_CYCLES. ON -> GAP at cnt = REFRESH_DIV-1. Any state -> OFF when enable_i = 0.
REQ-020 cnt counts 0..REFRESH_DIV-1 and then wraps. At the terminal count, idx advances 0->1->2->3->0. In OFF, cnt = 0 and idx = 0.
REQ-021 Outputs SHALL be registered and lag the cnt/idx/state values that produce them by exactly one cycle.
REQ-022 In OFF and GAP: an_o = 4'b1111 and dp_o = 1.
REQ-023 In ON: an_o[idx] = 0 unless the digit is blanked; dp_o = ~dp_active[idx]; digit_o = value_active[4*idx+:4].
REQ-024 Leading-zero blanking: with lzb active, digit k (k = 3..1) SHALL be blanked if it and all higher digits are 0. Digit 0 is never blanked by this rule.
REQ-025 A digit code > 9 SHALL be blanked and SHALL drive digit_o = 0. A blanked digit keeps an_o = 4'b1111 but still drives its dp_o.
REQ-026 frame_o SHALL pulse for one cycle, aligned with the first GAP output cycle of digit 0 after a wrap. It SHALL NOT pulse on OFF->GAP.
REQ-027 enable_i deasserted mid-slot: an_o = 4'b1111 on the next output cycle. A pending shadow frame SHALL be applied while in OFF.

Reset
REQ-028 While rst_ni = 0:
- an_o = 4'b1111, dp_o = 1, digit_o = 0, frame_o = 0, ready_o = 1.
- state = OFF, cnt = 0, idx = 0.
- active and shadow frames = 0 with lzb = 0; pending = 0.
REQ-029 Reset asserted mid-transfer: any captured but unapplied frame SHALL be discarded.

Verification
REQ-030 Basic scan (REFRESH_DIV = 8, DEAD_CYCLES = 2): load 16'h1234, enable -> per slot, 2 cycles an_o = 1111 then 6 cycles active. Active an_o sequence: 1110/digit 4, 1101/3, 1011/2, 0111/1. frame_o pulses every 32 cycles.
REQ-031 Double-buffer hold: offer 16'h5678 mid-frame -> ready_o drops the next cycle. Display stays 1234 until the wrap; 5678 appears in the digit-0 slot; ready_o returns to 1.
REQ-032 Leading-zero blanking: 16'h0050 with lzb = 1 -> digits 3 and 2 anodes stay 1111. 16'h0000 -> only digit 0 shows 0. With lzb = 0, all four digits are shown.
REQ-033 Invalid digit and dp: 16'h1A34 with dp_i = 4'b0100 -> digit-2 slot has an_o = 1111, digit_o = 0, dp_o = 0.
REQ-034 Enable/reset mid-slot: drop enable_i in the digit-2 ON phase -> an_o = 1111 next cycle; re-enable -> restart at digit 0 with no frame_o pulse. Assert rst_ni mid-slot -> all outputs return to reset values immediately (asynchronous).

Source files
------------

// File: rtl/sseg_scan_controller.sv
// rtl/sseg_scan_controller.sv - four-digit multiplexed 7-segment scan controller
// Double-buffered BCD frame, anti-ghost dead time, leading-zero and invalid-digit blanking.
module sseg_scan_controller #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        valid_i,
    input  logic [15:0] value_i,
    input  logic [3:0]  dp_i,
    input  logic        lzb_i,
    output logic        ready_o,
    output logic [3:0]  digit_o,
    output logic [3:0]  an_o,
    output logic        dp_o,
    output logic        frame_o
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {S_OFF, S_GAP, S_ON} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          wrap_d;

    logic [15:0] active_value, shadow_value;
    logic [3:0]  active_dp, shadow_dp;
    logic        active_lzb, shadow_lzb;
    logic        pending;

    logic       wrap, transfer, accept, shown, blank, lz_blank;
    logic [3:0] cur_digit;

    assign wrap     = enable_i && (state != S_OFF) && (cnt == CNT_LAST) && (idx == 2'd3);
    assign transfer = pending && (wrap || state == S_OFF);
    assign accept   = valid_i && !pending;
    assign ready_o  = !pending;

    // Gating on enable_i directly blanks the anodes on the very next output cycle.
    assign shown     = enable_i && (state == S_ON);
    assign cur_digit = active_value[{idx, 2'b00} +: 4];

    always_comb begin
        lz_blank = 1'b0;
        case (idx)
            2'd3: lz_blank = active_lzb && (active_value[15:12] == 4'd0);
            2'd2: lz_blank = active_lzb && (active_value[15:8] == 8'd0);
            2'd1: lz_blank = active_lzb && (active_value[15:4] == 12'd0);
            default: lz_blank = 1'b0;
        endcase
        blank = lz_blank || (cur_digit > 4'd9);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= S_OFF;
            cnt     <= '0;
            idx     <= 2'd0;
            wrap_d  <= 1'b0;
            an_o    <= 4'hF;
            dp_o    <= 1'b1;
            digit_o <= 4'd0;
            frame_o <= 1'b0;
        end else begin
            if (!enable_i) begin
                state <= S_OFF;
                cnt   <= '0;
                idx   <= 2'd0;
            end else begin
                case (state)
                    S_OFF: begin
                        state <= S_GAP;
                        cnt   <= '0;
                        idx   <= 2'd0;
                    end
                    default: begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            idx   <= idx + 2'd1;
                            state <= S_GAP;
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (state == S_GAP && cnt == GAP_LAST)
                                state <= S_ON;
                        end
                    end
                endcase
            end

            // wrap_d marks the first GAP cycle of digit 0 after a wrap.
            wrap_d  <= wrap;
            frame_o <= wrap_d && enable_i;
            an_o    <= (shown && !blank) ? ~(4'b0001 << idx) : 4'hF;
            dp_o    <= shown ? ~active_dp[idx] : 1'b1;
            digit_o <= (shown && !blank) ? cur_digit : 4'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_value <= 16'd0;
            active_dp    <= 4'd0;
            active_lzb   <= 1'b0;
            shadow_value <= 16'd0;
            shadow_dp    <= 4'd0;
            shadow_lzb   <= 1'b0;
            pending      <= 1'b0;
        end else if (transfer) begin
            active_value <= shadow_value;
            active_dp    <= shadow_dp;
            active_lzb   <= shadow_lzb;
            pending      <= 1'b0;
        end else if (accept) begin
            shadow_value <= value_i;
            shadow_dp    <= dp_i;
            shadow_lzb   <= lzb_i;
            pending      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// tb/tb_sseg_scan_controller.sv - randomized bench with a position-based scan reference model
module tb_sseg_scan_controller;

    localparam int RD    = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] value = 16'd0;
    logic [3:0]  dp_req = 4'd0;
    logic        lzb = 1'b0;
    logic        ready, dp_n, frame;
    logic [3:0]  digit, an;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: scanning is a single position 0..FRAME-1 within the four-digit frame.
    bit          m_on, m_wrapped, m_pend;
    int          m_pos;
    logic [15:0] m_av, m_sv;
    logic [3:0]  m_ad, m_sd;
    bit          m_al, m_sl;

    sseg_scan_controller #(.REFRESH_DIV(RD), .DEAD_CYCLES(DEAD)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .enable_i (enable),
        .valid_i  (valid),
        .value_i  (value),
        .dp_i     (dp_req),
        .lzb_i    (lzb),
        .ready_o  (ready),
        .digit_o  (digit),
        .an_o     (an),
        .dp_o     (dp_n),
        .frame_o  (frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_blank(input logic [15:0] v, input bit lz, input int slot);
        logic [15:0] t;
        t = v;
        if (((t >> (4 * slot)) & 16'hF) > 16'd9) return 1'b1;
        if (!lz || slot == 0) return 1'b0;
        for (int k = slot; k < 4; k++)
            if (((t >> (4 * k)) & 16'hF) != 16'd0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_on = 0; m_wrapped = 0; m_pend = 0; m_pos = 0;
        m_av = '0; m_sv = '0; m_ad = '0; m_sd = '0; m_al = 0; m_sl = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"},    an,    4'hF);
        check({tag, "_dp"},    dp_n,  1'b1);
        check({tag, "_digit"}, digit, 4'd0);
        check({tag, "_frame"}, frame, 1'b0);
        check({tag, "_ready"}, ready, 1'b1);
    endtask

    task automatic step(input logic en, input logic v, input logic [15:0] val,
                        input logic [3:0] dp, input logic lz);
        logic [3:0] e_an, e_digit;
        logic       e_dp, e_frame, e_ready;
        int         slot, phase;
        bit         shown, wrap, xfer, acc;
        enable = en; valid = v; value = val; dp_req = dp; lzb = lz;
        slot  = m_pos / RD;
        phase = m_pos % RD;
        shown = en && m_on && (phase >= DEAD);
        e_an = 4'hF; e_digit = 4'd0; e_dp = 1'b1;
        if (shown) begin
            e_dp = !m_ad[slot];
            if (!is_blank(m_av, m_al, slot)) begin
                e_an[slot] = 1'b0;
                e_digit    = m_av[4 * slot +: 4];
            end
        end
        e_frame = en && m_on && m_wrapped && (m_pos == 0);
        wrap = en && m_on && (m_pos == FRAME - 1);
        xfer = m_pend && (wrap || !m_on);
        acc  = v && !m_pend;
        if (xfer) begin
            m_av = m_sv; m_ad = m_sd; m_al = m_sl; m_pend = 0;
        end else if (acc) begin
            m_sv = val; m_sd = dp; m_sl = lz; m_pend = 1;
        end
        if (!en) begin
            m_on = 0; m_pos = 0; m_wrapped = 0;
        end else if (!m_on) begin
            m_on = 1; m_pos = 0; m_wrapped = 0;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
            if (wrap) m_wrapped = 1;
        end
        e_ready = !m_pend;
        @(posedge clk);
        #1;
        check("an",    an,    e_an);
        check("digit", digit, e_digit);
        check("dp",    dp_n,  e_dp);
        check("frame", frame, e_frame);
        check("ready", ready, e_ready);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'd0, 4'd0, 1'b0);
    endtask

    task automatic offer(input logic [15:0] val, input logic [3:0] dp, input logic lz);
        step(1'b1, 1'b1, val, dp, lz);
        idle(2 * FRAME + 4);
    endtask

    task automatic async_reset_mid_slot();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        enable = 1'b0; valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("post_rst");
    endtask

    function automatic logic [15:0] rand_value();
        logic [15:0] r;
        int          sel;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)      r[4 * k +: 4] = 4'd0;
            else if (sel < 9) r[4 * k +: 4] = 4'($urandom_range(1, 9));
            else              r[4 * k +: 4] = 4'($urandom_range(10, 15));
        end
        return r;
    endfunction

    initial begin
        logic rand_en;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load while off, then scan.
        step(1'b0, 1'b1, 16'h1234, 4'b0000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0);
        idle(3 * FRAME);

        // Mid-frame offer is held until the wrap.
        idle(RD + 3);
        offer(16'h5678, 4'b0000, 1'b0);

        offer(16'h0050, 4'b0000, 1'b1);
        offer(16'h0000, 4'b0000, 1'b1);
        offer(16'h0050, 4'b0000, 1'b0);
        offer(16'h1A34, 4'b0100, 1'b0);

        // Drop enable during the digit-2 ON phase, then re-enable.
        for (int g = 0; g < FRAME && !((m_pos / RD) == 2 && (m_pos % RD) >= DEAD); g++)
            idle(1);
        step(1'b0, 1'b0, 16'd0, 4'd0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 16'd0, 4'd0, 1'b0);
        idle(2 * FRAME);

        // A captured but unapplied frame is discarded by reset.
        idle(5);
        step(1'b1, 1'b1, 16'h9999, 4'hF, 1'b0);
        async_reset_mid_slot();
        idle(FRAME + 4);

        rand_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) rand_en = ~rand_en;
            step(rand_en, ($urandom_range(0, 7) == 0), rand_value(),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
